module_imm_gen_pipe: RTL and testbench

//  Registered immediate generator for the decode stage: takes instr_i[31:7] plus a 3-bit format select,

---
 rtl/imm_gen_pkg.sv | 16 +
 rtl/imm_format_comb.sv | 30 +++
 rtl/module_imm_gen_pipe.sv | 105 ++++++++++
 tb/tb_module_imm_gen_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types for the registered immediate generator: format select codes and
// occupancy states of the two-entry output buffer.
package imm_gen_pkg;
  localparam int IMM_SRC_W = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } imm_src_e;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_state_e;
endpackage

// File: rtl/imm_format_comb.sv
// Combinational immediate extraction for I/S/B/J/U/Z formats, extended to XLEN.
// Codes 110/111 give a zero immediate and raise illegal.
module imm_format_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);
  logic [31:0] raw;

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_Z:   raw = {27'b0, instr[19:15]};
      default: illegal = 1'b1;
    endcase
    // Z and illegal leave raw[31] clear, so a signed widen is correct for every format.
    imm = XLEN'(signed'(raw));
  end
endmodule

// File: rtl/module_imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and a registered ready_o.
// Define IMM_GEN_ILLEGAL_EN to carry an illegal-format flag (err_o) with each word.
module module_imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [24:0]          instr_i,
  input  logic [IMM_SRC_W-1:0] imm_src_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [XLEN-1:0]      imm_ext_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 err_o
);
  logic [XLEN-1:0]  fmt_imm;
  logic             fmt_ill;
  occ_state_e       state, state_nxt;
  logic [XLEN-1:0]  main_imm, skid_imm;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             acc, pop, load_main, load_skid, skid_to_main;

  imm_format_comb #(.XLEN(XLEN)) u_fmt (
    .instr   (instr_i),
    .imm_src (imm_src_i),
    .imm     (fmt_imm),
    .illegal (fmt_ill)
  );

  assign acc          = valid_i && ready_o;
  assign pop          = valid_o && ready_i;
  assign load_main    = acc && ((state == EMPTY) || (state == ONE && pop));
  assign load_skid    = acc && state == ONE && !pop;
  assign skid_to_main = state == TWO && pop;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (acc) state_nxt = ONE;
      ONE:     if (acc && !pop) state_nxt = TWO;
               else if (pop && !acc) state_nxt = EMPTY;
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // ready_o comes from the next state so it never depends combinationally on ready_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= EMPTY;
      ready_o  <= 1'b1;
      main_imm <= '0;
      main_tag <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else begin
      state   <= state_nxt;
      ready_o <= (state_nxt != TWO);
      if (load_main) begin
        main_imm <= fmt_imm;
        main_tag <= tag_i;
      end else if (skid_to_main) begin
        main_imm <= skid_imm;
        main_tag <= skid_tag;
      end
      if (load_skid) begin
        skid_imm <= fmt_imm;
        skid_tag <= tag_i;
      end
    end
  end

  assign valid_o   = (state != EMPTY);
  assign imm_ext_o = main_imm;
  assign tag_o     = main_tag;

`ifdef IMM_GEN_ILLEGAL_EN
  logic main_err, skid_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_err <= 1'b0;
      skid_err <= 1'b0;
    end else begin
      if (load_main)         main_err <= fmt_ill;
      else if (skid_to_main) main_err <= skid_err;
      if (load_skid)         skid_err <= fmt_ill;
    end
  end

  assign err_o = main_err;

  xlen_legal: assert property (@(posedge clk_i) (XLEN == 32 || XLEN == 64));
`else
  logic unused_ill;
  assign unused_ill = fmt_ill;
  assign err_o      = 1'b0;
`endif
endmodule

// File: tb/tb_module_imm_gen_pipe.sv
// Bench for module_imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus; a queue
// scoreboard pairs each accepted word with the result popped at the output.
module tb_module_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [24:0] instr_i = '0;
  logic [2:0]  imm_src_i = '0;
  logic [4:0]  tag_i = '0;
  logic        ready_o, valid_o, err_o;
  logic [31:0] imm_ext_o;
  logic [4:0]  tag_o;
  logic        ready64, valid64, err64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

`ifdef IMM_GEN_ILLEGAL_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  module_imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr_i),
    .imm_src_i(imm_src_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .imm_ext_o(imm_ext_o), .tag_o(tag_o), .err_o(err_o));

  module_imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready64), .instr_i(instr_i),
    .imm_src_i(imm_src_i), .tag_i(tag_i), .valid_o(valid64), .ready_i(ready_i),
    .imm_ext_o(imm64), .tag_o(tag64), .err_o(err64));

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t   q[$];
  vec_t   tbl[12];
  int     errors = 0;
  int     checks = 0;
  int     pops = 0;
  int     cycles = 0;
  bit     hold_prev = 1'b0;
  logic [31+64+5+1:0] prev_out;

  always @(posedge clk) cycles++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard and checks stability under backpressure.
  always @(negedge clk) begin
    if (rst_i) hold_prev = 1'b0;
    else begin
      if (hold_prev) chk("hold_stable", 64'({imm_ext_o, imm64, tag_o, err_o} != prev_out), 64'd0);
      if (valid_o && ready_i) begin
        if (q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("imm32", 64'(imm_ext_o), 64'(e.i32));
          chk("imm64", imm64, e.i64);
          chk("tag", 64'(tag_o), 64'(e.tag));
          chk("err", 64'(err_o), 64'(e.err));
          pops++;
        end
      end
      hold_prev = valid_o && !ready_i;
      prev_out  = {imm_ext_o, imm64, tag_o, err_o};
    end
  end

  // Drive one word starting just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, input logic [4:0] tg);
    exp_t e;
    bit   ok = 1'b0;
    valid_i   = 1'b1;
    instr_i   = v.ins[31:7];
    imm_src_i = v.src;
    tag_i     = tg;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (ready_o) begin
        ok    = 1'b1;
        e.i32 = v.e32;
        e.i64 = v.e64;
        e.tag = tg;
        e.err = ERR_EN & v.ill;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    if (!ok) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int p0, c0;
    tbl[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1]  = '{32'h7FF00093, 3'b000, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    tbl[2]  = '{32'hFE112E23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[3]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[4]  = '{32'h00000863, 3'b010, 32'h00000010, 64'h0000000000000010, 1'b0};
    tbl[5]  = '{32'hFFDFF06F, 3'b011, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[6]  = '{32'h123450B7, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0};
    tbl[7]  = '{32'h800000B7, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    tbl[8]  = '{32'h000F8073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0};
    tbl[9]  = '{32'h800F8073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0};
    tbl[10] = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[11] = '{32'hFFFFFFFF, 3'b110, 32'h00000000, 64'h0000000000000000, 1'b1};

    #12;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_imm", 64'(imm_ext_o), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Table vectors, streamed back to back.
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) send(tbl[i], 5'(i));
    drain();

    // Backpressure: two words fill the buffer, the third stalls.
    ready_i = 1'b0;
    p0 = pops;
    send(tbl[2], 5'd1);
    send(tbl[6], 5'd2);
    chk("bp_ready_low", 64'(ready_o), 64'd0);
    valid_i = 1'b1; instr_i = tbl[5].ins[31:7]; imm_src_i = tbl[5].src; tag_i = 5'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_stall", 64'(ready_o), 64'd0);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    send(tbl[5], 5'd3);
    drain();
    chk("bp_count", 64'(pops - p0), 64'd3);

    // Streaming: one word per cycle with no ready_o drop.
    p0 = pops;
    c0 = cycles;
    for (int i = 0; i < 20; i++) send(tbl[i % 10], 5'(i));
    chk("stream_cycles", 64'(cycles - c0), 64'd20);
    drain();
    chk("stream_count", 64'(pops - p0), 64'd20);

    // Asynchronous reset while holding two words.
    ready_i = 1'b0;
    send(tbl[0], 5'd7);
    send(tbl[1], 5'd8);
    chk("two_ready", 64'(ready_o), 64'd0);
    chk("two_valid", 64'(valid_o), 64'd1);
    #3 rst_i = 1'b1;
    #1;
    q.delete();
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd1);
    chk("arst_imm", 64'(imm_ext_o), 64'd0);
    chk("arst_imm64", imm64, 64'd0);
    chk("arst_tag", 64'(tag_o), 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    @(posedge clk); #1;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(valid_o), 64'd0);
    @(posedge clk); #1;
    send(tbl[10], 5'd9);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
